cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the functional units behind the reservation stations: ALU/add, multiplier and divider.
- Each FU hands a completed result to a one-entry holding buffer.
- A round-robin scheduler broadcasts one buffered result per cycle to the ROB, the reservation stations' wakeup logic and the physical register file.
- Sits between the FU outputs and the rename/dispatch consumers of ready physical registers.

Parameters:
- NUM_FU, 3, number of requesting functional units; index 0=add, 1=mul, 2=div.
- PHYS_REG_BITS, 6, physical register tag width.
- ROB_IDX_BITS, 6, ROB index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  mispredict/flush; discards all pending results.
- fu_valid  in  NUM_FU  per-FU result valid.
- fu_pkt  in  NUM_FU x cdb_pkt_t  per-FU result: pd, rd, rob_num, 32-bit data.
- fu_ready  out  NUM_FU  per-FU ready; a result is accepted when fu_valid[i] && fu_ready[i].
- cdb_valid  out  1  broadcast valid this cycle.
- cdb_pkt  out  cdb_pkt_t  broadcast payload.
- cdb_grant  out  NUM_FU  one-hot source of the current broadcast; zero when cdb_valid=0.

Behaviour:
- State:
  - buf_valid[NUM_FU] and buf_pkt[NUM_FU], one entry per FU.
  - rr_ptr, width clog2(NUM_FU).
- Reset (rst_n=0 at edge): buf_valid=0, buf_pkt=0, rr_ptr=0. Outputs in the cycle after reset: cdb_valid=0, cdb_pkt=0, cdb_grant=0, fu_ready=all 1.
- Arbitration is combinational on registered buffers only, never on fu_valid (no comb loop):
  - Scan i = rr_ptr, rr_ptr+1, ... mod NUM_FU. The first i with buf_valid[i] wins.
  - cdb_valid=|buf_valid, cdb_pkt=buf_pkt[winner], cdb_grant=onehot(winner).
  - cdb_pkt=0 when idle.
- fu_ready[i] = !buf_valid[i] || cdb_grant[i]. A FU whose buffer drains this cycle may refill in the same cycle.
- Buffer update per i at edge:
  - Accept: buf_valid[i]<=1, buf_pkt[i]<=fu_pkt[i].
  - Else if grant[i]: buf_valid[i]<=0.
  - Else: hold.
- rr_ptr update: on any grant, rr_ptr <= (winner+1) mod NUM_FU; otherwise hold.
- Latency: result accepted in cycle N is on the CDB no earlier than N+1.
- Worst-case wait: NUM_FU-1 cycles behind other buffered entries. No starvation.
- All NUM_FU buffers full: exactly one drains per cycle; only the granted FU sees fu_ready=1.
- rd=x0 results are broadcast unchanged; consumers filter.
- Flush (sampled at edge, highest priority after reset):
  - Buffers cleared, rr_ptr<=0, same-cycle accepts discarded.
  - cdb_valid is forced 0 combinationally during the flush cycle.
  - fu_ready remains per the normal rule.
- Reset mid-operation: pending buffered results are lost; no partial broadcast.

Optional Feature:
- Macro CDB_BYPASS_EN.
- Defined:
  - If all buffers are empty, the lowest FU index at or after rr_ptr with fu_valid=1 is broadcast combinationally in the same cycle (0-cycle latency).
  - That FU's buffer is not written; rr_ptr advances as for a normal grant. Other same-cycle valids are buffered normally.
  - Bypass is suppressed during flush.
- Undefined: all results go through buffers; latency is exactly as above.

Decomposition:
- Shared package rv32i_types gets:
  - cdb_pkt_t: packed struct {pd [PHYS_REG_BITS-1:0], rd [4:0], rob_num [ROB_IDX_BITS-1:0], data [31:0]}.
  - FU index constants FU_ADD=0, FU_MUL=1, FU_DIV=2.
- One sub-module is natural: rr_arbiter (req vector, ptr -> one-hot grant, winner index). Parameterized by NUM_FU and reusable for RS issue selection.

Test Plan:
- Reset with rst_n=0 for 2 cycles, then idle -> cdb_valid=0, fu_ready=3'b111, cdb_pkt=0.
- Single add result (pd=6'd12, rob=6'd3, data=32'hDEADBEEF) in cycle N -> cdb_valid=1 in N+1 with that payload, cdb_grant=3'b001; idle in N+2. With CDB_BYPASS_EN, broadcast occurs in cycle N.
- All three FUs valid in the same cycle with rr_ptr=0 -> broadcasts in order add, mul, div on N+1..N+3; fu_ready low for waiting FUs; rr_ptr=0 afterwards.
- Add unit valid every cycle while mul and div hold one result each -> grants interleave add/mul/div/add...; mul and div are each broadcast within 3 cycles.
- Flush asserted while all buffers are full and fu_valid=3'b111 -> cdb_valid=0 that cycle; next cycle buffers are empty, cdb_valid=0, rr_ptr=0.
- Granted FU refills in its drain cycle (buf full, grant[1], fu_valid[1]=1, new data 32'h1) -> fu_ready[1]=1; the new result is broadcast once its round-robin turn arrives.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared core types: the CDB broadcast packet and functional-unit indices.
package rv32i_types;

    localparam int PHYS_REG_BITS = 6;
    localparam int ROB_IDX_BITS  = 6;

    localparam int FU_ADD = 0;
    localparam int FU_MUL = 1;
    localparam int FU_DIV = 2;

    typedef struct packed {
        logic [PHYS_REG_BITS-1:0] pd;
        logic [4:0]               rd;
        logic [ROB_IDX_BITS-1:0]  rob_num;
        logic [31:0]              data;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Round-robin picker: first requester at or after i_ptr wins; returns one-hot grant and index.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    logic [PW-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = PW'((int'(i_ptr) + k) % N);
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_idx          = w_idx;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding buffer per FU, round-robin broadcast of one result per cycle.
// Define CDB_BYPASS_EN to broadcast straight from fu_pkt when every buffer is empty.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_FU = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [NUM_FU-1:0] fu_valid,
    input  cdb_pkt_t          fu_pkt [NUM_FU],
    output logic [NUM_FU-1:0] fu_ready,
    output logic              cdb_valid,
    output cdb_pkt_t          cdb_pkt,
    output logic [NUM_FU-1:0] cdb_grant
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0] r_buf_valid;
    cdb_pkt_t          r_buf_pkt [NUM_FU];
    logic [PTR_W-1:0]  r_rr_ptr;

    logic [NUM_FU-1:0] w_buf_grant;
    logic [PTR_W-1:0]  w_buf_idx;
    logic              w_buf_any;
    logic [NUM_FU-1:0] w_byp_grant;
    logic [PTR_W-1:0]  w_byp_idx;
    logic              w_byp_sel;
    logic [PTR_W-1:0]  w_win_idx;
    logic [PTR_W-1:0]  w_rr_next;
    logic              w_any;
    logic [NUM_FU-1:0] w_accept;

    // Arbitration looks only at registered buffers, so fu_ready never depends on fu_valid.
    rr_arbiter #(.N(NUM_FU), .PW(PTR_W)) u_rr_buf (
        .i_req   (r_buf_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_buf_grant),
        .o_idx   (w_buf_idx),
        .o_any   (w_buf_any)
    );

`ifdef CDB_BYPASS_EN
    logic [NUM_FU-1:0] w_byp_grant_raw;
    logic              w_byp_any;

    rr_arbiter #(.N(NUM_FU), .PW(PTR_W)) u_rr_byp (
        .i_req   (fu_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_byp_grant_raw),
        .o_idx   (w_byp_idx),
        .o_any   (w_byp_any)
    );

    assign w_byp_sel   = !flush && !w_buf_any && w_byp_any;
    assign w_byp_grant = w_byp_sel ? w_byp_grant_raw : '0;
`else
    assign w_byp_sel   = 1'b0;
    assign w_byp_grant = '0;
    assign w_byp_idx   = '0;
`endif

    always_comb begin
        w_any     = !flush && (w_buf_any || w_byp_sel);
        w_win_idx = w_buf_any ? w_buf_idx : w_byp_idx;
        cdb_valid = w_any;
        cdb_grant = '0;
        cdb_pkt   = '0;
        if (w_any) begin
            cdb_grant = w_buf_any ? w_buf_grant : w_byp_grant;
            cdb_pkt   = w_buf_any ? r_buf_pkt[w_buf_idx] : fu_pkt[w_byp_idx];
        end
        fu_ready  = ~r_buf_valid | cdb_grant;
        w_accept  = fu_valid & fu_ready & ~w_byp_grant;
        w_rr_next = (w_win_idx == PTR_W'(NUM_FU - 1)) ? '0 : w_win_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_buf_valid <= '0;
            r_rr_ptr    <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                r_buf_pkt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_accept[i]) begin
                    r_buf_valid[i] <= 1'b1;
                    r_buf_pkt[i]   <= fu_pkt[i];
                end else if (cdb_grant[i]) begin
                    r_buf_valid[i] <= 1'b0;
                end
            end
            if (w_any) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: per-cycle vector table plus per-FU payload scoreboard.
module tb_cdb_arbiter;
    import rv32i_types::*;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [2:0] fu_valid;
    cdb_pkt_t   fu_pkt [3];
    logic [2:0] fu_ready;
    logic       cdb_valid;
    cdb_pkt_t   cdb_pkt;
    logic [2:0] cdb_grant;

    cdb_arbiter #(.NUM_FU(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .fu_valid  (fu_valid),
        .fu_pkt    (fu_pkt),
        .fu_ready  (fu_ready),
        .cdb_valid (cdb_valid),
        .cdb_pkt   (cdb_pkt),
        .cdb_grant (cdb_grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit       rst_n;
        bit       flush;
        bit [2:0] valid;
        bit       chk;
        bit       chk_rdy;
        bit       exp_v;
        bit [2:0] exp_g;
        bit [2:0] exp_r;
    } vec_t;

    vec_t     vecs[$];
    cdb_pkt_t sb [3][$];
    int       checks   = 0;
    int       failures = 0;

    function automatic vec_t mk(bit r, bit f, bit [2:0] v, bit c, bit cr, bit ev,
                                bit [2:0] eg, bit [2:0] er);
        vec_t t;
        t.rst_n = r; t.flush = f; t.valid = v; t.chk = c; t.chk_rdy = cr;
        t.exp_v = ev; t.exp_g = eg; t.exp_r = er;
        return t;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vec_t     v;
        cdb_pkt_t e;
        int       f;
        int       n;

        // rst, flush, fu_valid, chk, chk_ready, exp_valid, exp_grant, exp_ready
        vecs.push_back(mk(0, 0, 3'b000, 0, 0, 0, 3'b000, 3'b000));
        vecs.push_back(mk(0, 0, 3'b000, 0, 0, 0, 3'b000, 3'b000));
        vecs.push_back(mk(1, 0, 3'b000, 1, 1, 0, 3'b000, 3'b111));  // 2 idle after reset
        vecs.push_back(mk(1, 0, 3'b001, 1, 1, 0, 3'b000, 3'b111));  // 3 single add
        vecs.push_back(mk(1, 0, 3'b000, 1, 1, 1, 3'b001, 3'b111));
        vecs.push_back(mk(1, 0, 3'b000, 1, 1, 0, 3'b000, 3'b111));
        vecs.push_back(mk(1, 1, 3'b000, 1, 1, 0, 3'b000, 3'b111));  // 6 flush -> ptr 0
        vecs.push_back(mk(1, 0, 3'b111, 1, 1, 0, 3'b000, 3'b111));  // 7 all three
        vecs.push_back(mk(1, 0, 3'b000, 1, 1, 1, 3'b001, 3'b001));
        vecs.push_back(mk(1, 0, 3'b000, 1, 1, 1, 3'b010, 3'b011));
        vecs.push_back(mk(1, 0, 3'b000, 1, 1, 1, 3'b100, 3'b111));
        vecs.push_back(mk(1, 0, 3'b000, 1, 1, 0, 3'b000, 3'b111));
        vecs.push_back(mk(1, 0, 3'b111, 1, 1, 0, 3'b000, 3'b111));  // 12 add streaming
        vecs.push_back(mk(1, 0, 3'b001, 1, 1, 1, 3'b001, 3'b001));
        vecs.push_back(mk(1, 0, 3'b001, 1, 1, 1, 3'b010, 3'b010));
        vecs.push_back(mk(1, 0, 3'b001, 1, 1, 1, 3'b100, 3'b110));
        vecs.push_back(mk(1, 0, 3'b001, 1, 1, 1, 3'b001, 3'b111));
        vecs.push_back(mk(1, 0, 3'b001, 1, 1, 1, 3'b001, 3'b111));
        vecs.push_back(mk(1, 0, 3'b000, 1, 1, 1, 3'b001, 3'b111));
        vecs.push_back(mk(1, 0, 3'b000, 1, 1, 0, 3'b000, 3'b111));
        vecs.push_back(mk(1, 0, 3'b111, 1, 1, 0, 3'b000, 3'b111));  // 20 fill, then flush
        vecs.push_back(mk(1, 1, 3'b111, 1, 0, 0, 3'b000, 3'b000));
        vecs.push_back(mk(1, 0, 3'b000, 1, 1, 0, 3'b000, 3'b111));
        vecs.push_back(mk(1, 0, 3'b111, 1, 1, 0, 3'b000, 3'b111));  // 23 ptr must be 0
        vecs.push_back(mk(1, 0, 3'b000, 1, 1, 1, 3'b001, 3'b001));
        vecs.push_back(mk(1, 0, 3'b010, 1, 1, 1, 3'b010, 3'b011));  // 25 mul refills on drain
        vecs.push_back(mk(1, 0, 3'b000, 1, 1, 1, 3'b100, 3'b101));
        vecs.push_back(mk(1, 0, 3'b000, 1, 1, 1, 3'b010, 3'b111));
        vecs.push_back(mk(1, 0, 3'b000, 1, 1, 0, 3'b000, 3'b111));
        vecs.push_back(mk(1, 0, 3'b111, 1, 1, 0, 3'b000, 3'b111));  // 29 reset mid-operation
        vecs.push_back(mk(0, 0, 3'b000, 1, 1, 1, 3'b100, 3'b100));
        vecs.push_back(mk(1, 0, 3'b000, 1, 1, 0, 3'b000, 3'b111));
        vecs.push_back(mk(1, 0, 3'b100, 1, 1, 0, 3'b000, 3'b111));
        vecs.push_back(mk(1, 0, 3'b000, 1, 1, 1, 3'b100, 3'b111));
        vecs.push_back(mk(1, 0, 3'b000, 1, 1, 0, 3'b000, 3'b111));

        rst_n    = 1'b0;
        flush    = 1'b0;
        fu_valid = '0;
        for (int k = 0; k < 3; k++) fu_pkt[k] = '0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            v        = vecs[i];
            rst_n    = v.rst_n;
            flush    = v.flush;
            fu_valid = v.valid;
            for (int k = 0; k < 3; k++) begin
                fu_pkt[k].pd      = 6'(i * 3 + k);
                fu_pkt[k].rd      = 5'(k + 1);
                fu_pkt[k].rob_num = 6'(i);
                fu_pkt[k].data    = $urandom;
            end
            if (i == 25) fu_pkt[1].data = 32'h1;
            #1;
            if (v.chk) begin
                check($sformatf("v%0d_valid", i), 64'(cdb_valid), 64'(v.exp_v));
                check($sformatf("v%0d_grant", i), 64'(cdb_grant), 64'(v.exp_g));
                if (v.chk_rdy) check($sformatf("v%0d_ready", i), 64'(fu_ready), 64'(v.exp_r));
                if (!v.exp_v) check($sformatf("v%0d_idle_pkt", i), 64'(cdb_pkt), 64'd0);
            end
            if (v.exp_v && cdb_valid) begin
                f = (v.exp_g == 3'b001) ? 0 : (v.exp_g == 3'b010) ? 1 : 2;
                if (sb[f].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL v%0d_sb_empty: broadcast from fu %0d with nothing expected", i, f);
                end else begin
                    e = sb[f].pop_front();
                    check($sformatf("v%0d_payload", i), 64'(cdb_pkt), 64'(e));
                end
            end
            if (!v.rst_n || v.flush) begin
                for (int k = 0; k < 3; k++) sb[k].delete();
            end else begin
                for (int k = 0; k < 3; k++)
                    if (v.valid[k] && v.exp_r[k]) sb[k].push_back(fu_pkt[k]);
            end
        end

        for (int k = 0; k < 3; k++)
            check($sformatf("sb_drained_fu%0d", k), 64'(sb[k].size()), 64'd0);

        // Single add with a known payload: broadcast one cycle after acceptance.
        @(negedge clk);
        fu_valid          = 3'b001;
        fu_pkt[0].pd      = 6'd12;
        fu_pkt[0].rd      = 5'd7;
        fu_pkt[0].rob_num = 6'd3;
        fu_pkt[0].data    = 32'hDEADBEEF;
        #1;
        check("add_same_cycle_valid", 64'(cdb_valid), 64'd0);
        @(negedge clk);
        fu_valid = 3'b000;
        #1;
        n = 0;
        while (!cdb_valid && n < 4) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("add_latency", 64'(n), 64'd0);
        check("add_grant", 64'(cdb_grant), 64'(3'b001));
        check("add_pd", 64'(cdb_pkt.pd), 64'd12);
        check("add_rob", 64'(cdb_pkt.rob_num), 64'd3);
        check("add_data", 64'(cdb_pkt.data), 64'hDEADBEEF);
        @(negedge clk);
        #1;
        check("add_after_valid", 64'(cdb_valid), 64'd0);
        check("add_after_pkt", 64'(cdb_pkt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
